// File: rtl/mk_tb_soc.sv
// mk_tb_soc: two-stage fetch/decode test SoC with epoch-tagged redirect and trap handling
module mk_tb_soc #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] TRAP_VEC  = 32'h0000_0100,
    parameter int          ROM_DEPTH = 256,
    parameter              ROM_FILE  = "boot.hex"
) (
    input  logic        CLK,
    input  logic        RST_N,
    output logic [74:0] decoder_func_32,
    output logic        EN_update_eEpoch,
    output logic        EN_update_wEpoch
);
    localparam int AW = $clog2(ROM_DEPTH);

    // Image is loaded by the surrounding environment; unwritten words read as zero.
    logic [31:0] rom [ROM_DEPTH] = '{default: 32'h0};

    logic [31:0] pc;
    logic [31:0] f_pc;
    logic [31:0] f_inst;
    logic        f_valid;
    logic        f_ee;
    logic        f_we;
    logic        e_epoch;
    logic        w_epoch;

    logic [6:0]  opcode;
    logic [3:0]  opclass;
    logic [19:0] imm20;
    logic [31:0] target;
    logic        live;
    logic        trap;
    logic        redirect;

    // Decode: classify the opcode and extract the format-specific immediate.
    always_comb begin
        opcode  = f_inst[6:0];
        opclass = (f_inst[1:0] != 2'b11)                          ? 4'd15 :
                  (opcode == 7'b0010011 || opcode == 7'b0110011) ? 4'd0  :
                  (opcode == 7'b0000011)                          ? 4'd1  :
                  (opcode == 7'b0100011)                          ? 4'd2  :
                  (opcode == 7'b1100011)                          ? 4'd3  :
                  (opcode == 7'b1101111)                          ? 4'd4  :
                  (opcode == 7'b1100111)                          ? 4'd5  :
                  (opcode == 7'b0110111)                          ? 4'd6  :
                  (opcode == 7'b0010111)                          ? 4'd7  :
                  (opcode == 7'b1110011)                          ? 4'd8  : 4'd15;
        imm20   = (opclass == 4'd1 || opclass == 4'd5 || opclass == 4'd8 || opcode == 7'b0010011) ?
                      {{8{f_inst[31]}}, f_inst[31:20]} :
                  (opclass == 4'd2) ? {{8{f_inst[31]}}, f_inst[31:25], f_inst[11:7]} :
                  (opclass == 4'd3) ? {{8{f_inst[31]}}, f_inst[31], f_inst[7], f_inst[30:25], f_inst[11:8]} :
                  (opclass == 4'd4) ? {f_inst[31], f_inst[19:12], f_inst[20], f_inst[30:21]} :
                  (opclass == 4'd6 || opclass == 4'd7) ? f_inst[31:12] : 20'h0;
        live     = f_valid && (f_ee == e_epoch) && (f_we == w_epoch);
        trap     = live && (opclass == 4'd8 || opclass == 4'd15);
        redirect = live && (opclass == 4'd4) && !trap;
        target   = f_pc + {{11{imm20[19]}}, imm20, 1'b0};
        decoder_func_32  = live ? {f_pc, f_inst[19:15], f_inst[24:20], f_inst[11:7], imm20, opclass, f_inst[14:12], 1'b1} : 75'h0;
        EN_update_eEpoch = redirect;
        EN_update_wEpoch = trap;
    end

    // Fetch into the pipeline register, steer the PC and flip epochs on redirect/trap.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            pc      <= RESET_PC;
            f_pc    <= 32'h0;
            f_inst  <= 32'h0;
            f_valid <= 1'b0;
            f_ee    <= 1'b0;
            f_we    <= 1'b0;
            e_epoch <= 1'b0;
            w_epoch <= 1'b0;
        end else begin
            f_pc    <= pc;
            f_inst  <= rom[pc[AW+1:2]];
            f_valid <= 1'b1;
            f_ee    <= e_epoch;
            f_we    <= w_epoch;
            pc      <= trap ? TRAP_VEC : redirect ? target : pc + 32'd4;
            e_epoch <= e_epoch ^ redirect;
            w_epoch <= w_epoch ^ trap;
        end
    end
endmodule

// File: tb/tb_mk_tb_soc.sv
// tb_mk_tb_soc: directed scoreboard bench for the fetch/decode SoC
module tb_mk_tb_soc;
    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic [74:0] pkt;
    logic        es;
    logic        ws;

    mk_tb_soc dut (
        .CLK(CLK),
        .RST_N(RST_N),
        .decoder_func_32(pkt),
        .EN_update_eEpoch(es),
        .EN_update_wEpoch(ws)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [74:0] pkt;
        logic        es;
        logic        ws;
    } exp_t;

    exp_t sb[$];
    int   pass_cnt = 0;
    int   total = 0;

    localparam logic [31:0] ADDI  = 32'h0050_0093;
    localparam logic [31:0] JAL8  = 32'h0080_006F;
    localparam logic [31:0] JALM  = 32'hED1F_F06F;
    localparam logic [31:0] ECALL = 32'h0000_0073;
    localparam logic [31:0] ILL   = 32'h0000_0000;
    localparam logic [31:0] LW    = 32'hFFC1_2283;
    localparam logic [31:0] SW    = 32'h0061_2423;
    localparam logic [31:0] BEQ   = 32'hFE20_88E3;
    localparam logic [31:0] LUI   = 32'h1234_51B7;
    localparam logic [31:0] AUIPC = 32'hFFFF_F217;
    localparam logic [31:0] JALR  = 32'h0102_80E7;
    localparam logic [31:0] ADD   = 32'h0094_03B3;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    function automatic logic [3:0] cls_of(logic [31:0] i);
        if (i[1:0] != 2'b11) return 4'd15;
        case (i[6:0])
            7'h13, 7'h33: return 4'd0;
            7'h03:        return 4'd1;
            7'h23:        return 4'd2;
            7'h63:        return 4'd3;
            7'h6F:        return 4'd4;
            7'h67:        return 4'd5;
            7'h37:        return 4'd6;
            7'h17:        return 4'd7;
            7'h73:        return 4'd8;
            default:      return 4'd15;
        endcase
    endfunction

    // Reference decode built from the full ISA immediates, then narrowed to the packet field.
    function automatic logic [74:0] model(logic [31:0] pc, logic [31:0] i);
        logic [3:0]  c;
        logic [31:0] imm;
        logic [19:0] f;
        c   = cls_of(i);
        imm = 32'h0;
        f   = 20'h0;
        case (c)
            4'd0:             imm = (i[6:0] == 7'h13) ? {{20{i[31]}}, i[31:20]} : 32'h0;
            4'd1, 4'd5, 4'd8: imm = {{20{i[31]}}, i[31:20]};
            4'd2:             imm = {{20{i[31]}}, i[31:25], i[11:7]};
            4'd3:             imm = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
            4'd4:             imm = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
            4'd6, 4'd7:       imm = {i[31:12], 12'h0};
            default:          imm = 32'h0;
        endcase
        case (c)
            4'd0, 4'd1, 4'd2, 4'd5, 4'd8: f = imm[19:0];
            4'd3, 4'd4:                   f = imm[20:1];
            4'd6, 4'd7:                   f = imm[31:12];
            default:                      f = 20'h0;
        endcase
        return {pc, i[19:15], i[24:20], i[11:7], f, c, i[14:12], 1'b1};
    endfunction

    task automatic check(input string tag, input logic [76:0] obs, input logic [76:0] exp);
        total++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic expect_live(input logic [31:0] pc, input logic [31:0] i);
        exp_t e;
        logic [3:0] c;
        c = cls_of(i);
        e.pkt = model(pc, i);
        e.es  = (c == 4'd4);
        e.ws  = (c == 4'd8 || c == 4'd15);
        sb.push_back(e);
    endtask

    task automatic expect_bubble();
        exp_t e;
        e.pkt = 75'h0;
        e.es  = 1'b0;
        e.ws  = 1'b0;
        sb.push_back(e);
    endtask

    task automatic step(input string tag);
        exp_t e;
        @(posedge CLK);
        #1;
        if (sb.size() == 0) begin
            total++;
            $error("FAIL %s scoreboard empty observed=%h expected=entry", tag, {pkt, es, ws});
        end else begin
            e = sb.pop_front();
            check(tag, {pkt, es, ws}, {e.pkt, e.es, e.ws});
        end
    endtask

    task automatic run(input logic [31:0] pc, input logic [31:0] i);
        expect_live(pc, i);
        step($sformatf("pkt@%h", pc));
    endtask

    task automatic bubble(input string tag);
        expect_bubble();
        step(tag);
    endtask

    initial begin
        for (int k = 0; k < 256; k++) dut.rom[k] = 32'h0;
        dut.rom[0]   = ADDI;
        dut.rom[1]   = JAL8;
        dut.rom[2]   = ECALL;
        dut.rom[3]   = ILL;
        dut.rom[4]   = NOP;
        dut.rom[64]  = LW;
        dut.rom[65]  = SW;
        dut.rom[66]  = BEQ;
        dut.rom[67]  = LUI;
        dut.rom[68]  = AUIPC;
        dut.rom[69]  = JALR;
        dut.rom[70]  = ADD;
        dut.rom[71]  = JAL8;
        dut.rom[72]  = ECALL;
        dut.rom[73]  = JAL8;
        dut.rom[74]  = JAL8;
        dut.rom[75]  = JALM;
        dut.rom[76]  = NOP;
        dut.rom[255] = ECALL;

        for (int k = 0; k < 3; k++) begin
            @(posedge CLK);
            #1;
            check("reset_hold", {pkt, es, ws}, 77'h0);
        end
        check("reset_pc", dut.pc, 32'h0);
        @(negedge CLK) RST_N = 1'b1;

        run(32'h0, ADDI);
        check("addi_fields", pkt, {32'h0, 5'd0, 5'd5, 5'd1, 20'd5, 4'd0, 3'd0, 1'b1});
        run(32'h4, JAL8);
        bubble("jal_bubble");
        check("e_epoch_after_jal", dut.e_epoch, 1);
        run(32'hC, ILL);
        check("jal_target_pc", pkt[74:43], 32'hC);
        check("illegal_class", pkt[7:4], 4'd15);
        bubble("trap_bubble");
        check("w_epoch_after_trap", dut.w_epoch, 1);
        run(32'h100, LW);
        run(32'h104, SW);
        run(32'h108, BEQ);
        run(32'h10C, LUI);
        run(32'h110, AUIPC);
        run(32'h114, JALR);
        run(32'h118, ADD);
        run(32'h11C, JAL8);
        bubble("b2b_bubble1");
        check("e_epoch_b2b1", dut.e_epoch, 0);
        run(32'h124, JAL8);
        bubble("b2b_bubble2");
        check("e_epoch_b2b2", dut.e_epoch, 1);
        run(32'h12C, JALM);
        bubble("wrap_bubble");
        run(32'hFFFF_FFFC, ECALL);
        check("ecall_class", pkt[7:4], 4'd8);
        bubble("ecall_bubble");
        check("epochs_after_ecall", {dut.e_epoch, dut.w_epoch}, 2'b00);
        run(32'h100, LW);

        RST_N = 1'b0;
        #1;
        check("async_reset_out", {pkt, es, ws}, 77'h0);
        check("async_reset_pc", dut.pc, 32'h0);
        @(negedge CLK) RST_N = 1'b1;
        run(32'h0, ADDI);
        run(32'h4, JAL8);
        RST_N = 1'b0;
        #1;
        check("reset_kills_strobe", {pkt, es, ws}, 77'h0);
        @(posedge CLK);
        #1;
        check("no_toggle_in_reset", {dut.e_epoch, dut.w_epoch}, 2'b00);
        @(negedge CLK) RST_N = 1'b1;
        run(32'h0, ADDI);
        check("epochs_after_restart", {dut.e_epoch, dut.w_epoch}, 2'b00);
        run(32'h4, JAL8);
        bubble("restart_bubble");
        run(32'hC, ILL);
        check("sb_drained", sb.size(), 0);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule
